core_msg_receiver: RTL and testbench

Per-core receiver that consumes the scheduler's 16-bit broadcast message bus and its four loading strobes. It decodes whether this core belongs to the current task, captures the r0 init words and instruction words into local buffers, and starts execution. It returns this core's `core_reading` bit to the scheduler and gates scheduler progress while the core is busy. One instance sits in each core; the top level concatenates the 16 `core_reading` bits.

---
 rtl/core_msg_receiver_pkg.sv | 44 ++++
 rtl/core_msg_receiver_imem.sv | 36 +++
 rtl/core_msg_receiver.sv | 175 +++++++++++++++++
 tb/tb_core_msg_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_msg_receiver_pkg.sv
// Shared definitions for the per-core message receiver: bus width, frame
// constants, FSM state encoding and the loading-strobe priority decode.
package core_msg_receiver_pkg;

   // Width of the scheduler's broadcast message bus
   localparam int SCHED_MSG_BUS_WIDTH = 16;

   // r0 data words carried per task (frame slots 3..15)
   localparam int CMR_R0_WORDS = 13;

   // Instruction word that terminates a program
   localparam logic [SCHED_MSG_BUS_WIDTH-1:0] CMR_END_WORD = 16'hFFFF;

   // Receiver FSM states (kept as plain constants for legacy tooling)
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_MASK  = 3'd1;
   localparam logic [2:0] ST_R0    = 3'd2;
   localparam logic [2:0] ST_INSTR = 3'd3;
   localparam logic [2:0] ST_EXEC  = 3'd4;

   // Winning strobe after priority resolution, highest priority first
   typedef enum logic [2:0] {
      STB_NONE      = 3'd0,
      STB_CORE_MASK = 3'd1,
      STB_R0_MASK   = 3'd2,
      STB_R0        = 3'd3,
      STB_INSTR     = 3'd4
   } strobe_e;

   // core_mask beats r0_mask beats r0 beats instr; losers are ignored
   function automatic strobe_e decode_strobe(input logic core_mask,
                                             input logic r0_mask,
                                             input logic r0_word,
                                             input logic instr_word);
      strobe_e s;
      s = STB_NONE;
      if (core_mask)       s = STB_CORE_MASK;
      else if (r0_mask)    s = STB_R0_MASK;
      else if (r0_word)    s = STB_R0;
      else if (instr_word) s = STB_INSTR;
      return s;
   endfunction

endpackage

// File: rtl/core_msg_receiver_imem.sv
// Instruction buffer for one core: single write port fed by the message
// receiver, registered read port used by the core. A same-address read and
// write returns the old contents.
module core_imem_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:DEPTH-1];

   // Storage array is not reset; contents are undefined until written
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read, cleared on reset so the core sees zero after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/core_msg_receiver.sv
// Per-core receiver for the scheduler's broadcast message bus. Decodes task
// membership from the core mask, captures r0 init words and the program into
// local buffers, pulses exec_start once the END word arrives and holds
// core_reading low while the core executes.
// Optional build macro CORE_MSG_RX_ERR_EN adds the sticky rx_err port.
module core_msg_receiver
   import core_msg_receiver_pkg::*;
#(
   parameter int                 CORE_ID    = 0,
   parameter int                 BUS_W      = SCHED_MSG_BUS_WIDTH,
   parameter int                 R0_WORDS   = CMR_R0_WORDS,
   parameter int                 IMEM_DEPTH = 64,
   parameter int                 IMEM_AW    = 6,
   parameter logic [BUS_W-1:0]   END_WORD   = CMR_END_WORD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BUS_W-1:0]   mess_to_core,
   input  logic               core_mask_loading,
   input  logic               r0_mask_loading,
   input  logic               r0_loading,
   input  logic               instr_loading,
   output logic               core_reading,
   output logic               selected,
   output logic               r0_init,
   output logic               exec_start,
   output logic [IMEM_AW:0]   instr_len,
   input  logic [IMEM_AW-1:0] imem_raddr,
   output logic [BUS_W-1:0]   imem_rdata,
   input  logic [3:0]         r0_raddr,
   output logic [BUS_W-1:0]   r0_rdata,
`ifdef CORE_MSG_RX_ERR_EN
   output logic [2:0]         rx_err,
`endif
   input  logic               core_done
);

   localparam logic [3:0]       R0_LAST  = 4'(R0_WORDS);
   localparam logic [IMEM_AW:0] I_FULL   = (IMEM_AW+1)'(IMEM_DEPTH);

   logic [2:0]         state;
   logic [3:0]         r0_cnt;
   logic [IMEM_AW:0]   i_cnt;
   logic [BUS_W-1:0]   r0_buf [0:R0_WORDS-1];

   strobe_e            strobe;
   logic               my_bit;
   logic               r0_acc;
   logic               r0_we;
   logic               instr_acc;
   logic               instr_end;
   logic               imem_we;

   // Resolve strobes and derive the per-cycle accept/write qualifiers
   always_comb begin
      strobe    = decode_strobe(core_mask_loading, r0_mask_loading,
                                r0_loading, instr_loading);
      my_bit    = mess_to_core[CORE_ID];
      r0_acc    = (state == ST_R0) && (strobe == STB_R0);
      r0_we     = r0_acc && r0_init && (r0_cnt != R0_LAST);
      instr_acc = ((state == ST_R0) || (state == ST_INSTR)) && (strobe == STB_INSTR);
      instr_end = instr_acc && (mess_to_core == END_WORD);
      imem_we   = instr_acc && !instr_end && (i_cnt != I_FULL);
   end

   // The scheduler is only stalled while this core is executing
   always_comb begin
      core_reading = (state != ST_EXEC);
   end

   // Receiver FSM: mask decode, r0 capture, program capture and execution hold
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         selected   <= 1'b0;
         r0_init    <= 1'b0;
         exec_start <= 1'b0;
         instr_len  <= '0;
         r0_cnt     <= '0;
         i_cnt      <= '0;
      end else begin
         exec_start <= 1'b0;
         if (state == ST_EXEC) begin
            if (core_done) begin
               state    <= ST_IDLE;
               i_cnt    <= '0;
               selected <= 1'b0;
               r0_init  <= 1'b0;
            end
         end else if (strobe == STB_CORE_MASK) begin
            selected <= my_bit;
            state    <= my_bit ? ST_MASK : ST_IDLE;
            r0_cnt   <= '0;
            i_cnt    <= '0;
         end else begin
            if ((state == ST_MASK) && (strobe == STB_R0_MASK)) begin
               r0_init <= my_bit;
               r0_cnt  <= '0;
               state   <= ST_R0;
            end
            if (r0_acc && (r0_cnt != R0_LAST)) begin
               r0_cnt <= r0_cnt + 4'd1;
            end
            if (instr_end) begin
               instr_len  <= i_cnt;
               exec_start <= 1'b1;
               state      <= ST_EXEC;
            end else if (instr_acc) begin
               state <= ST_INSTR;
               if (imem_we) begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end
         end
      end
   end

   // r0 buffer is plain storage with no reset; unselected r0 words are dropped
   always_ff @(posedge clk) begin
      if (r0_we) begin
         r0_buf[r0_cnt] <= mess_to_core;
      end
   end

   // Combinational r0 read; addresses past the last r0 slot read as zero
   always_comb begin
      r0_rdata = '0;
      if (int'(r0_raddr) < R0_WORDS) begin
         r0_rdata = r0_buf[r0_raddr];
      end
   end

   core_imem_buf #(
      .DEPTH (IMEM_DEPTH),
      .AW    (IMEM_AW),
      .DW    (BUS_W)
   ) u_imem (
      .clk   (clk),
      .reset (reset),
      .we    (imem_we),
      .waddr (i_cnt[IMEM_AW-1:0]),
      .wdata (mess_to_core),
      .raddr (imem_raddr),
      .rdata (imem_rdata)
   );

`ifdef CORE_MSG_RX_ERR_EN
   logic [2:0] strobe_sum;
   logic       err_r0_ovf;
   logic       err_imem_ovf;
   logic       err_proto;

   // Classify overflow and protocol violations seen this cycle
   always_comb begin
      strobe_sum   = 3'(core_mask_loading) + 3'(r0_mask_loading)
                   + 3'(r0_loading) + 3'(instr_loading);
      err_r0_ovf   = r0_acc && (r0_cnt == R0_LAST);
      err_imem_ovf = instr_acc && !instr_end && (i_cnt == I_FULL);
      err_proto    = (strobe_sum > 3'd1)
                   || ((state == ST_EXEC) && (strobe == STB_CORE_MASK) && my_bit)
                   || (((state == ST_IDLE) || (state == ST_MASK)) && selected
                       && ((strobe == STB_R0) || (strobe == STB_INSTR)));
   end

   // Sticky error flags, cleared by reset or when the core finishes a task
   always_ff @(posedge clk) begin
      if (reset || core_done) begin
         rx_err <= '0;
      end else begin
         rx_err <= rx_err | {err_proto, err_imem_ovf, err_r0_ovf};
      end
   end
`endif

endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed self-checking bench for core_msg_receiver with CORE_ID=3.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_core_msg_receiver;

   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_CM   = 4'b1000;
   localparam logic [3:0] S_RM   = 4'b0100;
   localparam logic [3:0] S_R0   = 4'b0010;
   localparam logic [3:0] S_IN   = 4'b0001;

   logic        clk;
   logic        reset;
   logic [15:0] mess_to_core;
   logic        core_mask_loading;
   logic        r0_mask_loading;
   logic        r0_loading;
   logic        instr_loading;
   logic        core_reading;
   logic        selected;
   logic        r0_init;
   logic        exec_start;
   logic [6:0]  instr_len;
   logic [5:0]  imem_raddr;
   logic [15:0] imem_rdata;
   logic [3:0]  r0_raddr;
   logic [15:0] r0_rdata;
   logic        core_done;
`ifdef CORE_MSG_RX_ERR_EN
   logic [2:0]  rx_err;
`endif

   int checks;
   int errors;

   core_msg_receiver #(
      .CORE_ID (3)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .mess_to_core      (mess_to_core),
      .core_mask_loading (core_mask_loading),
      .r0_mask_loading   (r0_mask_loading),
      .r0_loading        (r0_loading),
      .instr_loading     (instr_loading),
      .core_reading      (core_reading),
      .selected          (selected),
      .r0_init           (r0_init),
      .exec_start        (exec_start),
      .instr_len         (instr_len),
      .imem_raddr        (imem_raddr),
      .imem_rdata        (imem_rdata),
      .r0_raddr          (r0_raddr),
      .r0_rdata          (r0_rdata),
`ifdef CORE_MSG_RX_ERR_EN
      .rx_err            (rx_err),
`endif
      .core_done         (core_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one bus word with the given strobes for exactly one clock
   task automatic applyStimulus(input logic [3:0] stb, input logic [15:0] word);
      mess_to_core      = word;
      core_mask_loading = stb[3];
      r0_mask_loading   = stb[2];
      r0_loading        = stb[1];
      instr_loading     = stb[0];
      @(negedge clk);
      core_mask_loading = 1'b0;
      r0_mask_loading   = 1'b0;
      r0_loading        = 1'b0;
      instr_loading     = 1'b0;
   endtask

   task automatic pulseDone();
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic readImem(input logic [5:0] addr);
      imem_raddr = addr;
      applyStimulus(S_NONE, 16'h0000);
   endtask

   task automatic readR0(input logic [3:0] addr);
      r0_raddr = addr;
      #1;
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      reset             = 1'b1;
      mess_to_core      = '0;
      core_mask_loading = 1'b0;
      r0_mask_loading   = 1'b0;
      r0_loading        = 1'b0;
      instr_loading     = 1'b0;
      imem_raddr        = '0;
      r0_raddr          = '0;
      core_done         = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_core_reading", 32'(core_reading), 32'd1);
      checkOutput("rst_selected",     32'(selected),     32'd0);
      checkOutput("rst_r0_init",      32'(r0_init),      32'd0);
      checkOutput("rst_exec_start",   32'(exec_start),   32'd0);
      checkOutput("rst_instr_len",    32'(instr_len),    32'd0);
      checkOutput("rst_imem_rdata",   32'(imem_rdata),   32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] full load for core 3");
      applyStimulus(S_CM, 16'h0008);
      checkOutput("t1_selected", 32'(selected), 32'd1);
      applyStimulus(S_RM, 16'h0008);
      checkOutput("t1_r0_init", 32'(r0_init), 32'd1);
      for (int i = 0; i < 13; i++) applyStimulus(S_R0, 16'h0100 + 16'(i));
      for (int i = 0; i < 5; i++)  applyStimulus(S_IN, 16'hA000 + 16'(i));
      checkOutput("t1_reading_before_end", 32'(core_reading), 32'd1);
      checkOutput("t1_no_start_early", 32'(exec_start), 32'd0);
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t1_exec_start",  32'(exec_start),   32'd1);
      checkOutput("t1_instr_len",   32'(instr_len),    32'd5);
      checkOutput("t1_reading_low", 32'(core_reading), 32'd0);
      applyStimulus(S_NONE, 16'h0000);
      checkOutput("t1_start_pulse_once", 32'(exec_start), 32'd0);
      checkOutput("t1_reading_held", 32'(core_reading), 32'd0);
      readR0(4'd5);
      checkOutput("t1_r0_5", 32'(r0_rdata), 32'h0105);
      readR0(4'd12);
      checkOutput("t1_r0_12", 32'(r0_rdata), 32'h010C);
      readImem(6'd2);
      checkOutput("t1_imem_2", 32'(imem_rdata), 32'hA002);
      applyStimulus(S_CM, 16'h0008);
      checkOutput("t1_exec_mask_set_reading", 32'(core_reading), 32'd0);
`ifdef CORE_MSG_RX_ERR_EN
      checkOutput("t1_err_proto", 32'(rx_err), 32'd4);
`endif
      applyStimulus(S_CM, 16'h0004);
      checkOutput("t1_exec_mask_clr_selected", 32'(selected), 32'd1);
      checkOutput("t1_exec_mask_clr_reading", 32'(core_reading), 32'd0);
      pulseDone();
      checkOutput("t1_done_reading",  32'(core_reading), 32'd1);
      checkOutput("t1_done_selected", 32'(selected),     32'd0);
      checkOutput("t1_done_r0_init",  32'(r0_init),      32'd0);
`ifdef CORE_MSG_RX_ERR_EN
      checkOutput("t1_err_cleared", 32'(rx_err), 32'd0);
`endif

      $display("[TB] other task, core 3 not selected");
      applyStimulus(S_CM, 16'h0004);
      checkOutput("t2_selected", 32'(selected), 32'd0);
      applyStimulus(S_RM, 16'h0008);
      checkOutput("t2_r0_init", 32'(r0_init), 32'd0);
      for (int i = 0; i < 13; i++) applyStimulus(S_R0, 16'h0200 + 16'(i));
      applyStimulus(S_IN, 16'hB000);
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t2_no_exec_start", 32'(exec_start),   32'd0);
      checkOutput("t2_reading",       32'(core_reading), 32'd1);
      checkOutput("t2_instr_len",     32'(instr_len),    32'd5);
      readR0(4'd5);
      checkOutput("t2_r0_5_kept", 32'(r0_rdata), 32'h0105);
      readImem(6'd0);
      checkOutput("t2_imem_0_kept", 32'(imem_rdata), 32'hA000);

      $display("[TB] selected with r0 mask clear");
      applyStimulus(S_CM, 16'h0008);
      applyStimulus(S_RM, 16'h0000);
      checkOutput("t3_r0_init", 32'(r0_init), 32'd0);
      for (int i = 0; i < 13; i++) applyStimulus(S_R0, 16'h0300 + 16'(i));
      applyStimulus(S_IN, 16'hC000);
      applyStimulus(S_IN, 16'hC001);
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t3_exec_start", 32'(exec_start), 32'd1);
      checkOutput("t3_instr_len",  32'(instr_len),  32'd2);
      readR0(4'd5);
      checkOutput("t3_r0_5_unwritten", 32'(r0_rdata), 32'h0105);
      readImem(6'd1);
      checkOutput("t3_imem_1", 32'(imem_rdata), 32'hC001);
      pulseDone();

      $display("[TB] r0 and imem overflow");
      applyStimulus(S_CM, 16'h0008);
      applyStimulus(S_RM, 16'h0008);
      for (int i = 0; i < 15; i++) applyStimulus(S_R0, 16'h0400 + 16'(i));
      for (int i = 0; i < 70; i++) applyStimulus(S_IN, 16'hD000 + 16'(i));
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t4_instr_len", 32'(instr_len), 32'd64);
      checkOutput("t4_exec_start", 32'(exec_start), 32'd1);
      readR0(4'd12);
      checkOutput("t4_r0_12", 32'(r0_rdata), 32'h040C);
      readImem(6'd63);
      checkOutput("t4_imem_63", 32'(imem_rdata), 32'hD03F);
      readImem(6'd0);
      checkOutput("t4_imem_0", 32'(imem_rdata), 32'hD000);
`ifdef CORE_MSG_RX_ERR_EN
      checkOutput("t4_rx_err", 32'(rx_err), 32'd3);
`endif
      pulseDone();

      $display("[TB] restart after partial program");
      applyStimulus(S_CM, 16'h0008);
      applyStimulus(S_RM, 16'h0000);
      applyStimulus(S_IN, 16'hE000);
      pulseDone();
      checkOutput("t5_done_ignored", 32'(selected), 32'd1);
      applyStimulus(S_IN, 16'hE001);
      applyStimulus(S_IN, 16'hE002);
      applyStimulus(S_CM | S_IN, 16'h0008);
      checkOutput("t5_restart_selected", 32'(selected), 32'd1);
`ifdef CORE_MSG_RX_ERR_EN
      checkOutput("t5_multi_strobe_err", 32'(rx_err[2]), 32'd1);
`endif
      applyStimulus(S_RM, 16'h0008);
      applyStimulus(S_IN, 16'hE100);
      applyStimulus(S_IN, 16'hE101);
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t5_instr_len", 32'(instr_len), 32'd2);
      readImem(6'd0);
      checkOutput("t5_imem_0", 32'(imem_rdata), 32'hE100);
      readImem(6'd2);
      checkOutput("t5_imem_2_old", 32'(imem_rdata), 32'hE002);
      pulseDone();

      $display("[TB] reset during instruction load");
      applyStimulus(S_CM, 16'h0008);
      applyStimulus(S_RM, 16'h0008);
      applyStimulus(S_IN, 16'hF000);
      applyStimulus(S_IN, 16'hF001);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t6_reading",    32'(core_reading), 32'd1);
      checkOutput("t6_selected",   32'(selected),     32'd0);
      checkOutput("t6_exec_start", 32'(exec_start),   32'd0);
      checkOutput("t6_instr_len",  32'(instr_len),    32'd0);
      reset = 1'b0;
      applyStimulus(S_IN, 16'hFFFF);
      checkOutput("t6_end_ignored", 32'(exec_start), 32'd0);
      readImem(6'd0);
      checkOutput("t6_imem_kept", 32'(imem_rdata), 32'hF000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
